// File: rtl/trig_lut_reader.sv
// Fixed-latency front-end for the 36-bit trig ROM: index handshake, dual-port ROM addressing,
// sin/cos linear interpolation and an output FIFO. Interpolation is enabled by TRIG_LUT_INTERP_EN.
module trig_lut_reader #(
  parameter int DataWidth    = 36,
  parameter int AddressRange = 197,
  parameter int AddressWidth = 8,
  parameter int FracWidth    = 6,
  parameter int FifoDepth    = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [AddressWidth+FracWidth-1:0] in_idx,
  output logic [AddressWidth-1:0]         address0,
  output logic                            ce0,
  input  logic [DataWidth-1:0]            q0,
  output logic [AddressWidth-1:0]         address1,
  output logic                            ce1,
  input  logic [DataWidth-1:0]            q1,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [DataWidth/2-1:0]          out_sin,
  output logic [DataWidth/2-1:0]          out_cos
);

  localparam int HalfW = DataWidth / 2;
  localparam int IdxW  = AddressWidth + FracWidth;
  localparam int CntW  = $clog2(FifoDepth + 1);
  localparam int PtrW  = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;

  localparam logic [AddressWidth-1:0] RangeA = AddressWidth'(AddressRange);
  localparam logic [CntW-1:0]         DepthC = CntW'(FifoDepth);
  localparam logic [PtrW-1:0]         LastP  = PtrW'(FifoDepth - 1);

  logic                    accept;
  logic                    pop;
  logic [AddressWidth-1:0] int_raw;
  logic [AddressWidth-1:0] int_wrap;

  assign accept = in_valid && in_ready;

  // One subtraction is enough: the raw integer never reaches twice the table size.
  always_comb begin
    int_raw  = in_idx[IdxW-1:FracWidth];
    int_wrap = (int_raw >= RangeA) ? (int_raw - RangeA) : int_raw;
  end

`ifdef TRIG_LUT_INTERP_EN
  localparam logic [AddressWidth-1:0] LastA = AddressWidth'(AddressRange - 1);

  logic [AddressWidth-1:0] int_next;
  logic [FracWidth-1:0]    frac_s1;
  logic [FracWidth-1:0]    frac_s2;

  always_comb begin
    int_next = (int_wrap == LastA) ? '0 : (int_wrap + AddressWidth'(1));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      frac_s1 <= '0;
      frac_s2 <= '0;
    end else begin
      if (accept) begin
        frac_s1 <= in_idx[FracWidth-1:0];
      end
      frac_s2 <= frac_s1;
    end
  end

  // r = a + floor((b - a) * f / 2^FracWidth); r always lies between a and b.
  function automatic logic [HalfW-1:0] lerp(
    input logic [HalfW-1:0]     a,
    input logic [HalfW-1:0]     b,
    input logic [FracWidth-1:0] f
  );
    logic signed [HalfW:0]             d;
    logic signed [HalfW+FracWidth+1:0] p;
    logic signed [HalfW+FracWidth+1:0] sh;
    logic signed [HalfW+FracWidth+1:0] sum;
    d   = $signed({b[HalfW-1], b}) - $signed({a[HalfW-1], a});
    p   = $signed({{(FracWidth+1){d[HalfW]}}, d}) * $signed({{(HalfW+2){1'b0}}, f});
    sh  = p >>> FracWidth;
    sum = $signed({{(FracWidth+2){a[HalfW-1]}}, a}) + sh;
    return sum[HalfW-1:0];
  endfunction
`else
  logic unused_nearest;
  assign unused_nearest = ^{q1, in_idx[FracWidth-1:0]};
`endif

  // Stage 1: ROM address/enable registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      address0 <= '0;
      address1 <= '0;
      ce0      <= 1'b0;
      ce1      <= 1'b0;
    end else begin
      ce0 <= accept;
`ifdef TRIG_LUT_INTERP_EN
      ce1 <= accept;
      if (accept) begin
        address0 <= int_wrap;
        address1 <= int_next;
      end
`else
      ce1      <= 1'b0;
      address1 <= '0;
      if (accept) begin
        address0 <= int_wrap;
      end
`endif
    end
  end

  // Stage 2 is the ROM's own read register; stage 3 captures the result.
  logic             v_s2;
  logic             v_s3;
  logic [HalfW-1:0] res_sin;
  logic [HalfW-1:0] res_cos;

  always_ff @(posedge clk) begin
    if (reset) begin
      v_s2 <= 1'b0;
      v_s3 <= 1'b0;
    end else begin
      v_s2 <= ce0;
      v_s3 <= v_s2;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      res_sin <= '0;
      res_cos <= '0;
    end else if (v_s2) begin
`ifdef TRIG_LUT_INTERP_EN
      res_sin <= lerp(q0[DataWidth-1:HalfW], q1[DataWidth-1:HalfW], frac_s2);
      res_cos <= lerp(q0[HalfW-1:0], q1[HalfW-1:0], frac_s2);
`else
      res_sin <= q0[DataWidth-1:HalfW];
      res_cos <= q0[HalfW-1:0];
`endif
    end
  end

  // Stage 4: output FIFO.
  logic [DataWidth-1:0] mem [FifoDepth];
  logic [PtrW-1:0]      wr_ptr;
  logic [PtrW-1:0]      rd_ptr;
  logic [CntW-1:0]      count;

  assign out_valid = (count != '0);
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (v_s3) begin
        wr_ptr <= (wr_ptr == LastP) ? '0 : (wr_ptr + PtrW'(1));
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == LastP) ? '0 : (rd_ptr + PtrW'(1));
      end
      case ({v_s3, pop})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (v_s3) begin
      mem[wr_ptr] <= {res_sin, res_cos};
    end
  end

  always_comb begin
    out_sin = '0;
    out_cos = '0;
    if (out_valid) begin
      out_sin = mem[rd_ptr][DataWidth-1:HalfW];
      out_cos = mem[rd_ptr][HalfW-1:0];
    end
  end

  // Credits cover everything in the pipeline plus the FIFO, so the FIFO can never overflow.
  logic [CntW-1:0] credit;
  logic [CntW-1:0] credit_next;

  always_comb begin
    credit_next = credit;
    case ({accept, pop})
      2'b10:   credit_next = credit + CntW'(1);
      2'b01:   credit_next = credit - CntW'(1);
      default: credit_next = credit;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      credit   <= '0;
      in_ready <= 1'b0;
    end else begin
      credit   <= credit_next;
      in_ready <= (credit_next < DepthC);
    end
  end

endmodule

// File: tb/tb_trig_lut_reader.sv
// Self-checking bench for trig_lut_reader with a behavioural ROM and an expected-result queue.
module tb_trig_lut_reader;
  localparam int RANGE = 197;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [13:0] in_idx;
  logic [7:0]  address0;
  logic        ce0;
  logic [35:0] q0;
  logic [7:0]  address1;
  logic        ce1;
  logic [35:0] q1;
  logic        out_valid;
  logic        out_ready;
  logic [17:0] out_sin;
  logic [17:0] out_cos;

  trig_lut_reader dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_idx(in_idx),
    .address0(address0), .ce0(ce0), .q0(q0),
    .address1(address1), .ce1(ce1), .q1(q1),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sin(out_sin), .out_cos(out_cos)
  );

  always #5 clk = ~clk;

  logic [35:0] rom [RANGE];
  initial begin
    q0 = '0;
    q1 = '0;
  end
  always @(posedge clk) begin
    if (ce0) q0 <= rom[address0];
    if (ce1) q1 <= rom[address1];
  end

  int          checks = 0;
  int          failures = 0;
  logic [35:0] sb [$];
  logic [35:0] e_word;
  bit          ce1_seen = 1'b0;
  bit          addr1_seen = 1'b0;

  function automatic logic [35:0] model(input logic [13:0] idx);
    int          i;
    logic [35:0] wa;
`ifdef TRIG_LUT_INTERP_EN
    int          j;
    int          f;
    int          a;
    int          b;
    int          r;
    logic [35:0] wb;
    logic [17:0] rs;
    logic [17:0] rc;
`endif
    i = int'(idx[13:6]);
    if (i >= RANGE) i = i - RANGE;
    wa = rom[i];
`ifdef TRIG_LUT_INTERP_EN
    j  = (i == RANGE - 1) ? 0 : i + 1;
    f  = int'(idx[5:0]);
    wb = rom[j];
    a  = int'($signed(wa[35:18]));
    b  = int'($signed(wb[35:18]));
    r  = a + (((b - a) * f) >>> 6);
    rs = r[17:0];
    a  = int'($signed(wa[17:0]));
    b  = int'($signed(wb[17:0]));
    r  = a + (((b - a) * f) >>> 6);
    rc = r[17:0];
    return {rs, rc};
`else
    return wa;
`endif
  endfunction

  // Scoreboard: push on accept, pop and compare on every output transfer.
  always @(negedge clk) begin
    if (ce1) ce1_seen = 1'b1;
    if (address1 != 8'd0) addr1_seen = 1'b1;
    if (!reset) begin
      if (in_valid && in_ready) sb.push_back(model(in_idx));
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected: got sin=%h cos=%h, required no output", out_sin, out_cos);
        end else begin
          e_word = sb.pop_front();
          if ({out_sin, out_cos} !== e_word) begin
            failures++;
            $display("FAIL sb_data: got sin=%h cos=%h, required sin=%h cos=%h",
                     out_sin, out_cos, e_word[35:18], e_word[17:0]);
          end
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drain;
    int n;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    repeat (2) tick();
    checks++;
    if (sb.size() != 0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL drain: got %0d pending out_valid=%b, required 0 pending out_valid=0", sb.size(), out_valid);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; in_valid = 1'b0; in_idx = '0; out_ready = 1'b0;
    repeat (3) tick();
    checks++;
    if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready: got %b, required 0", in_ready); end
    checks++;
    if ({ce0, ce1, address0, address1} !== 18'd0) begin
      failures++;
      $display("FAIL reset_rom_port: got ce0=%b ce1=%b a0=%0d a1=%0d, required all 0", ce0, ce1, address0, address1);
    end
    checks++;
    if ({out_valid, out_sin, out_cos} !== 37'd0) begin
      failures++;
      $display("FAIL reset_out: got v=%b sin=%h cos=%h, required 0", out_valid, out_sin, out_cos);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL post_reset_in_ready: got %b, required 1", in_ready); end
    checks++;
    if ({ce0, ce1, out_valid} !== 3'b000) begin
      failures++;
      $display("FAIL post_reset_idle: got ce0=%b ce1=%b v=%b, required 0", ce0, ce1, out_valid);
    end
  endtask

  task automatic test_latency;
    out_ready = 1'b0;
    in_idx = {8'd10, 6'd0};
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    checks++;
    if (ce0 !== 1'b1 || address0 !== 8'd10) begin
      failures++;
      $display("FAIL lat_port0: got ce0=%b a0=%0d, required ce0=1 a0=10", ce0, address0);
    end
`ifdef TRIG_LUT_INTERP_EN
    checks++;
    if (ce1 !== 1'b1 || address1 !== 8'd11) begin
      failures++;
      $display("FAIL lat_port1: got ce1=%b a1=%0d, required ce1=1 a1=11", ce1, address1);
    end
`else
    checks++;
    if (ce1 !== 1'b0 || address1 !== 8'd0) begin
      failures++;
      $display("FAIL lat_port1: got ce1=%b a1=%0d, required ce1=0 a1=0", ce1, address1);
    end
`endif
    tick();
    checks++;
    if (ce0 !== 1'b0) begin failures++; $display("FAIL lat_ce_pulse: got ce0=%b, required 0", ce0); end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL lat_early: got out_valid=%b, required 0", out_valid); end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_sin !== 18'h04000 || out_cos !== 18'h10000) begin
      failures++;
      $display("FAIL lat_result: got v=%b sin=%h cos=%h, required v=1 sin=04000 cos=10000", out_valid, out_sin, out_cos);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL lat_pop: got out_valid=%b, required 0", out_valid); end
  endtask

  task automatic test_interp;
    int n;
    out_ready = 1'b0;
    in_idx = {8'd20, 6'd32};
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
`ifdef TRIG_LUT_INTERP_EN
    checks++;
    if (address1 !== 8'd21) begin failures++; $display("FAIL interp_a1: got %0d, required 21", address1); end
`endif
    n = 0;
    while (!out_valid && n < 10) begin
      tick();
      n++;
    end
    checks++;
`ifdef TRIG_LUT_INTERP_EN
    if (out_valid !== 1'b1 || out_sin !== 18'h00180 || out_cos !== 18'h3FEFF) begin
      failures++;
      $display("FAIL interp_result: got v=%b sin=%h cos=%h, required v=1 sin=00180 cos=3feff", out_valid, out_sin, out_cos);
    end
`else
    if (out_valid !== 1'b1 || out_sin !== 18'h00100 || out_cos !== 18'h3FF00) begin
      failures++;
      $display("FAIL nearest_result: got v=%b sin=%h cos=%h, required v=1 sin=00100 cos=3ff00", out_valid, out_sin, out_cos);
    end
`endif
    drain();
  endtask

  task automatic test_wrap;
    logic [13:0] widx [5];
    int          wa0 [5];
    int          wa1 [5];
    widx[0] = {8'd196, 6'd0};  wa0[0] = 196; wa1[0] = 0;
    widx[1] = {8'd200, 6'd0};  wa0[1] = 3;   wa1[1] = 4;
    widx[2] = {8'd255, 6'd63}; wa0[2] = 58;  wa1[2] = 59;
    widx[3] = {8'd197, 6'd1};  wa0[3] = 0;   wa1[3] = 1;
    widx[4] = {8'd195, 6'd40}; wa0[4] = 195; wa1[4] = 196;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      in_idx = widx[k];
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
`ifndef TRIG_LUT_INTERP_EN
      wa1[k] = 0;
`endif
      checks++;
      if (int'(address0) != wa0[k] || int'(address1) != wa1[k]) begin
        failures++;
        $display("FAIL wrap_%0d: got a0=%0d a1=%0d, required a0=%0d a1=%0d", k, address0, address1, wa0[k], wa1[k]);
      end
    end
    drain();
  endtask

  task automatic test_back_to_back;
    int acc;
    out_ready = 1'b1;
    acc = 0;
    for (int c = 0; c < 30; c++) begin
      in_idx = 14'($urandom);
      in_valid = 1'b1;
      if (in_ready) acc++;
      tick();
    end
    in_valid = 1'b0;
    checks++;
    if (acc != 30) begin failures++; $display("FAIL throughput: got %0d accepts, required 30", acc); end
    drain();
  endtask

  task automatic test_backpressure;
    int       k;
    bit       acc;
    logic [35:0] head;
    out_ready = 1'b0;
    k = 0;
    in_idx = {8'(k), 6'd0};
    in_valid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      acc = in_valid && in_ready;
      tick();
      if (acc) begin
        k++;
        in_idx = {8'(k), 6'd0};
      end
    end
    checks++;
    if (k != DEPTH || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_accepts: got %0d in_ready=%b, required %0d in_ready=0", k, in_ready, DEPTH);
    end
    head = {out_sin, out_cos};
    repeat (2) tick();
    checks++;
    if (out_valid !== 1'b1 || {out_sin, out_cos} !== head || head !== rom[0]) begin
      failures++;
      $display("FAIL bp_hold: got v=%b head=%h, required v=1 head=%h", out_valid, {out_sin, out_cos}, rom[0]);
    end
    out_ready = 1'b1;
    tick();
    checks++;
    if (in_ready !== 1'b1) begin failures++; $display("FAIL bp_ready_return: got %b, required 1", in_ready); end
    for (int c = 0; c < 40 && k < 16; c++) begin
      acc = in_valid && in_ready;
      tick();
      if (acc) begin
        k++;
        in_idx = {8'(k), 6'd0};
      end
    end
    in_valid = 1'b0;
    checks++;
    if (k != 16) begin failures++; $display("FAIL bp_resume: got %0d accepts, required 16", k); end
    drain();
  endtask

  task automatic test_random;
    for (int c = 0; c < 200; c++) begin
      in_valid  = ($urandom_range(0, 1) == 1);
      in_idx    = 14'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();
  endtask

  task automatic test_reset_midflight;
    int seen;
    out_ready = 1'b0;
    in_valid = 1'b1;
    in_idx = {8'd30, 6'd17}; tick();
    in_idx = {8'd31, 6'd5};  tick();
    in_valid = 1'b0;
    repeat (4) tick();
    checks++;
    if (out_valid !== 1'b1) begin failures++; $display("FAIL mid_buffered: got out_valid=%b, required 1", out_valid); end
    in_valid = 1'b1;
    in_idx = {8'd40, 6'd9};  tick();
    in_idx = {8'd41, 6'd33}; tick();
    in_idx = {8'd42, 6'd63}; tick();
    reset = 1'b1;
    in_valid = 1'b0;
    sb.delete();
    tick();
    checks++;
    if (out_valid !== 1'b0 || ce0 !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_reset: got v=%b ce0=%b rdy=%b, required all 0", out_valid, ce0, in_ready);
    end
    tick();
    reset = 1'b0;
    out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (out_valid) seen++;
    end
    checks++;
    if (seen != 0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL mid_stale: got %0d stale outputs rdy=%b, required 0 and rdy=1", seen, in_ready);
    end
  endtask

  task automatic test_port1_mode;
    checks++;
`ifdef TRIG_LUT_INTERP_EN
    if (ce1_seen !== 1'b1 || addr1_seen !== 1'b1) begin
      failures++;
      $display("FAIL port1_active: got ce1_seen=%b a1_seen=%b, required 1", ce1_seen, addr1_seen);
    end
`else
    if (ce1_seen !== 1'b0 || addr1_seen !== 1'b0) begin
      failures++;
      $display("FAIL port1_idle: got ce1_seen=%b a1_seen=%b, required 0", ce1_seen, addr1_seen);
    end
`endif
  endtask

  initial begin
    for (int i = 0; i < RANGE; i++) rom[i] = {18'($urandom), 18'($urandom)};
    rom[10] = {18'h04000, 18'h10000};
    rom[20] = {18'h00100, 18'h3FF00};
    rom[21] = {18'h00200, 18'h3FEFF};
    test_reset();
    test_latency();
    test_interp();
    test_wrap();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_midflight();
    test_port1_mode();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1);
  end

endmodule
